tia_lfsr_counter: RTL and testbench

//   Parametrised XNOR-feedback LFSR counter with programmable terminal state.

---
 rtl/tia_lfsr_counter.sv | 110 +++++++++++
 tb/tb_tia_lfsr_counter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tia_lfsr_counter.sv
// tia_lfsr_counter: parametrised XNOR-feedback LFSR counter with a programmable terminal state.
// Define LOCKUP_DETECT_EN to add sticky all-ones lockup detection and recovery (lockup port).
module tia_lfsr_counter #(
  parameter int unsigned      WIDTH     = 6,
  parameter logic [WIDTH-1:0] TAPS      = 6'b110000,
  parameter logic [WIDTH-1:0] END_STATE = 6'b001010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             rsyn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             rsynd
`ifdef LOCKUP_DETECT_EN
  ,
  output logic             lockup
`endif
);

  // One action is taken per clock, chosen by a fixed priority.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_RESTART,
    ACT_LOAD,
    ACT_WRAP,
    ACT_RECOVER,
    ACT_STEP
  } action_e;

`ifdef LOCKUP_DETECT_EN
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
`endif

  action_e          action_c;
  logic             fb_c;
  logic [WIDTH-1:0] out_nxt;
  logic             wrap_nxt;
`ifdef LOCKUP_DETECT_EN
  logic             lockup_nxt;
`endif

  // Action select: rsyn > load > terminal wrap > lockup recovery > step > hold.
  always_comb begin
    action_c = ACT_HOLD;
    if (rsyn) begin
      action_c = ACT_RESTART;
    end else if (load) begin
      action_c = ACT_LOAD;
    end else if (en && (out == END_STATE)) begin
      action_c = ACT_WRAP;
`ifdef LOCKUP_DETECT_EN
    end else if (en && (out == ALL_ONES)) begin
      action_c = ACT_RECOVER;
`endif
    end else if (en) begin
      action_c = ACT_STEP;
    end
  end

  // XNOR of the tapped bits; all-ones maps onto itself.
  assign fb_c = ~^(out & TAPS);

  // Next-state and next-output decode.
  always_comb begin
    out_nxt  = out;
    wrap_nxt = 1'b0;
`ifdef LOCKUP_DETECT_EN
    lockup_nxt = lockup;
`endif
    unique case (action_c)
      ACT_RESTART: out_nxt = '0;
      ACT_LOAD:    out_nxt = load_value;
      ACT_WRAP: begin
        out_nxt  = '0;
        wrap_nxt = 1'b1;
      end
      ACT_RECOVER: begin
        out_nxt = '0;
`ifdef LOCKUP_DETECT_EN
        lockup_nxt = 1'b1;
`endif
      end
      ACT_STEP:    out_nxt = {out[WIDTH-2:0], fb_c};
      default:     out_nxt = out;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out   <= '0;
      wrap  <= 1'b0;
      rsynd <= 1'b0;
`ifdef LOCKUP_DETECT_EN
      lockup <= 1'b0;
`endif
    end else begin
      out   <= out_nxt;
      wrap  <= wrap_nxt;
      rsynd <= rsyn;
`ifdef LOCKUP_DETECT_EN
      lockup <= lockup_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_tia_lfsr_counter.sv
// Self-checking bench for tia_lfsr_counter: default 6-bit instance plus an 8-bit instance
// whose terminal state (all-ones) is unreachable from 0. Honours LOCKUP_DETECT_EN.
module tb_tia_lfsr_counter;

  typedef struct packed {
    logic [5:0] out;
    logic       wrap;
    logic       rsynd;
    logic       lockup;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       en, rsyn, load;
  logic [5:0] load_value;
  logic [5:0] out;
  logic       wrap, rsynd;
  logic       lockup;
  logic       en8;
  logic [7:0] out8;
  logic       wrap8, rsynd8;
  logic       lockup8;

  int tests = 0;
  int fails = 0;

  exp_t       sbq[$];
  logic [5:0] m_out;
  logic       m_lock;
  logic [7:0] m8;
  logic [5:0] first6 [6] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E};

  tia_lfsr_counter dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .rsyn       (rsyn),
    .load       (load),
    .load_value (load_value),
    .out        (out),
    .wrap       (wrap),
    .rsynd      (rsynd)
`ifdef LOCKUP_DETECT_EN
    ,
    .lockup     (lockup)
`endif
  );

  tia_lfsr_counter #(
    .WIDTH     (8),
    .TAPS      (8'hB8),
    .END_STATE (8'hFF)
  ) dut8 (
    .clk        (clk),
    .reset      (reset),
    .en         (en8),
    .rsyn       (1'b0),
    .load       (1'b0),
    .load_value (8'h00),
    .out        (out8),
    .wrap       (wrap8),
    .rsynd      (rsynd8)
`ifdef LOCKUP_DETECT_EN
    ,
    .lockup     (lockup8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference LFSR step: XNOR of the tapped bits, bit by bit.
  function automatic logic [7:0] lfsr_nxt(input logic [7:0] s, input logic [7:0] taps,
                                          input int w);
    logic p;
    p = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (b < w && taps[b]) p = p ^ s[b];
    end
    return 8'(((s << 1) | {7'b0, p}) & 8'((1 << w) - 1));
  endfunction

  // Drive one cycle of 6-bit stimulus, predict, then compare after the edge.
  task automatic step(input logic e, input logic r, input logic l, input logic [5:0] lv);
    exp_t x;
    en = e; rsyn = r; load = l; load_value = lv;
    x.wrap = 1'b0;
    x.rsynd = r;
    if (r) m_out = 6'h00;
    else if (l) m_out = lv;
    else if (e && m_out == 6'h0A) begin m_out = 6'h00; x.wrap = 1'b1; end
`ifdef LOCKUP_DETECT_EN
    else if (e && m_out == 6'h3F) begin m_out = 6'h00; m_lock = 1'b1; end
`endif
    else if (e) m_out = 6'(lfsr_nxt({2'b00, m_out}, 8'h30, 6));
    x.out = m_out;
    x.lockup = m_lock;
    sbq.push_back(x);
    @(posedge clk); #1;
    x = sbq.pop_front();
    chk("out", 32'(out), 32'(x.out));
    chk("wrap", 32'(wrap), 32'(x.wrap));
    chk("rsynd", 32'(rsynd), 32'(x.rsynd));
`ifdef LOCKUP_DETECT_EN
    chk("lockup", 32'(lockup), 32'(x.lockup));
`endif
  endtask

  task automatic step8();
    logic w;
    w = 1'b0;
    en8 = 1'b1;
    if (m8 == 8'hFF) begin m8 = 8'h00; w = 1'b1; end
    else m8 = lfsr_nxt(m8, 8'hB8, 8);
    @(posedge clk); #1;
    chk("out8", 32'(out8), 32'(m8));
    chk("wrap8", 32'(wrap8), 32'(w));
  endtask

  initial begin
    int wrap_cnt, w1, w2, zero_cnt, wrap8_cnt;
    wrap_cnt = 0; w1 = 0; w2 = 0; zero_cnt = 0; wrap8_cnt = 0;
    reset = 1'b1; en = 1'b0; rsyn = 1'b0; load = 1'b0; load_value = 6'h00; en8 = 1'b0;
    m_out = 6'h00; m_lock = 1'b0; m8 = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_wrap", 32'(wrap), 32'h0);
    chk("reset_rsynd", 32'(rsynd), 32'h0);
`ifdef LOCKUP_DETECT_EN
    chk("reset_lockup", 32'(lockup), 32'h0);
`endif
    reset = 1'b0;

    // Free run over two full periods.
    for (int i = 1; i <= 114; i++) begin
      step(1'b1, 1'b0, 1'b0, 6'h00);
      if (i <= 6) chk("seq_start", 32'(out), 32'(first6[i-1]));
      if (i == 56) chk("step56_end", 32'(out), 32'h0A);
      if (i == 57) chk("step57_zero", 32'(out), 32'h00);
      if (wrap) begin
        wrap_cnt++;
        if (wrap_cnt == 1) w1 = i;
        else w2 = i;
      end
    end
    chk("wrap_count", 32'(wrap_cnt), 32'd2);
    chk("wrap_at_57", 32'(w1), 32'd57);
    chk("wrap_at_114", 32'(w2), 32'd114);

    // Pause at 3E, then resume.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 6'h00);
    chk("at_3e", 32'(out), 32'h3E);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 6'h00);
      chk("hold_3e", 32'(out), 32'h3E);
    end
    step(1'b1, 1'b0, 1'b0, 6'h00);
    chk("resume_3d", 32'(out), 32'h3D);

    // Restart on the terminal cycle suppresses wrap.
    for (int n = 0; n < 64 && m_out != 6'h0A; n++) step(1'b1, 1'b0, 1'b0, 6'h00);
    chk("reach_0a", 32'(out), 32'h0A);
    step(1'b1, 1'b1, 1'b0, 6'h00);
    chk("rsyn_out", 32'(out), 32'h00);
    chk("rsyn_wrap", 32'(wrap), 32'h0);
    chk("rsyn_rsynd", 32'(rsynd), 32'h1);
    step(1'b1, 1'b0, 1'b0, 6'h00);
    chk("rsynd_drop", 32'(rsynd), 32'h0);
    chk("after_rsyn", 32'(out), 32'h01);

    // Parallel load near the terminal state.
    step(1'b1, 1'b0, 1'b1, 6'h25);
    chk("load_25", 32'(out), 32'h25);
    step(1'b1, 1'b0, 1'b0, 6'h00);
    chk("load_next_0a", 32'(out), 32'h0A);
    step(1'b1, 1'b0, 1'b0, 6'h00);
    chk("load_wrap_out", 32'(out), 32'h00);
    chk("load_wrap", 32'(wrap), 32'h1);

    // All-ones lockup state.
    step(1'b1, 1'b0, 1'b1, 6'h3F);
    chk("load_3f", 32'(out), 32'h3F);
`ifdef LOCKUP_DETECT_EN
    step(1'b1, 1'b0, 1'b0, 6'h00);
    chk("recover_out", 32'(out), 32'h00);
    chk("recover_lockup", 32'(lockup), 32'h1);
    step(1'b1, 1'b1, 1'b0, 6'h00);
    chk("lockup_sticky", 32'(lockup), 32'h1);
`else
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 6'h00);
    chk("stuck_3f", 32'(out), 32'h3F);
`endif

    // Asynchronous reset mid-cycle.
    step(1'b1, 1'b1, 1'b0, 6'h00);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 6'h00);
    chk("at_1f", 32'(out), 32'h1F);
    #3 reset = 1'b1;
    #1;
    chk("async_out", 32'(out), 32'h00);
    chk("async_wrap", 32'(wrap), 32'h0);
    chk("async_rsynd", 32'(rsynd), 32'h0);
`ifdef LOCKUP_DETECT_EN
    chk("async_lockup", 32'(lockup), 32'h0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    m_out = 6'h00; m_lock = 1'b0; m8 = 8'h00;
    step(1'b0, 1'b0, 1'b0, 6'h00);
    step(1'b1, 1'b0, 1'b0, 6'h00);
    chk("post_reset_01", 32'(out), 32'h01);
    en = 1'b0;

    // 8-bit, terminal state unreachable: natural period 255, no wrap.
    for (int i = 1; i <= 255; i++) begin
      step8();
      if (i == 1) chk("w8_first", 32'(out8), 32'h01);
      if (out8 == 8'h00) zero_cnt++;
      if (wrap8) wrap8_cnt++;
    end
    chk("w8_period_zero", 32'(out8), 32'h00);
    chk("w8_zero_once", 32'(zero_cnt), 32'd1);
    chk("w8_no_wrap", 32'(wrap8_cnt), 32'd0);
    en8 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
